// File: rtl/pingpong_frame_ctrl_if.sv
// pingpong_frame_ctrl_if: bit-writer and frame-consumer handshake bundle for the ping-pong controller.
interface pingpong_frame_ctrl_if #(
  parameter int IDX_W  = 9,
  parameter int DROP_W = 16
);
  logic              bit_valid;
  logic              wr_en;
  logic              wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic              frame_valid;
  logic              frame_ready;
  logic              frame_done;
  logic              rd_bank;
  logic [1:0]        bank_full;
  logic              overflow;
  logic [DROP_W-1:0] frames_dropped;
  modport master (
    input  bit_valid, frame_ready, frame_done,
    output wr_en, wr_bank, wr_idx, frame_valid, rd_bank, bank_full, overflow, frames_dropped
  );
  modport slave (
    output bit_valid, frame_ready, frame_done,
    input  wr_en, wr_bank, wr_idx, frame_valid, rd_bank, bank_full, overflow, frames_dropped
  );
endinterface

// File: rtl/pingpong_frame_ctrl.sv
// pingpong_frame_ctrl: two-bank ping-pong sequencer between a serial bit writer and a frame consumer.
module pingpong_frame_ctrl #(
  parameter int FRAME_LEN = 512,
  parameter int IDX_W     = $clog2(FRAME_LEN),
  parameter int DROP_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  pingpong_frame_ctrl_if.master bus
);
  typedef enum logic {WRITE, DROP} wr_state_e;
  typedef enum logic [1:0] {IDLE, OFFER, BUSY} rd_state_e;

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;

  logic       frame_end, accept, release_bank, other_free, own_free;
  logic [1:0] clr_mask, set_mask, full_after;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q    <= WRITE;
      rd_state_q    <= IDLE;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      dropped_q     <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
      dropped_q     <= dropped_d;
    end
  end

  // A bank released this cycle already counts as free for the next-bank choice.
  always_comb begin
    frame_end    = bus.bit_valid && wr_idx_q == IDX_W'(FRAME_LEN - 1);
    accept       = rd_state_q == OFFER && frame_valid_q && bus.frame_ready;
    release_bank = rd_state_q == BUSY && bus.frame_done;
    clr_mask     = release_bank ? 2'b01 << rd_bank_q : 2'b00;
    set_mask     = (wr_state_q == WRITE && frame_end) ? 2'b01 << wr_bank_q : 2'b00;
    full_after   = bank_full_q & ~clr_mask;
    other_free   = !full_after[~wr_bank_q];
    own_free     = !full_after[wr_bank_q];
    wr_state_d   = wr_state_q;
    wr_bank_d    = wr_bank_q;
    if (frame_end) begin
      if (other_free) begin
        wr_bank_d  = ~wr_bank_q;
        wr_state_d = WRITE;
      end else if (wr_state_q == DROP && own_free)
        wr_state_d = WRITE;
      else
        wr_state_d = DROP;
    end
    wr_idx_d      = bus.bit_valid ? wr_idx_q + IDX_W'(1) : wr_idx_q;
    bank_full_d   = full_after | set_mask;
    dropped_d     = (wr_state_q == DROP && frame_end && !(&dropped_q)) ? dropped_q + DROP_W'(1) : dropped_q;
    overflow_d    = wr_state_q == DROP && bus.bit_valid && wr_idx_q == '0;
    rd_state_d    = rd_state_q == IDLE  ? (bank_full_q[rd_bank_q] ? OFFER : IDLE) :
                    rd_state_q == OFFER ? (accept ? BUSY : OFFER) :
                                          (release_bank ? IDLE : BUSY);
    rd_bank_d     = release_bank ? ~rd_bank_q : rd_bank_q;
    frame_valid_d = rd_state_q == OFFER && !accept;
  end

  always_comb begin
    bus.wr_en          = bus.bit_valid && wr_state_q == WRITE;
    bus.wr_bank        = wr_bank_q;
    bus.wr_idx         = wr_idx_q;
    bus.frame_valid    = frame_valid_q;
    bus.rd_bank        = rd_bank_q;
    bus.bank_full      = bank_full_q;
    bus.overflow       = overflow_q;
    bus.frames_dropped = dropped_q;
  end
endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// tb_pingpong_frame_ctrl: directed scenarios for the ping-pong frame controller with an 8-bit frame.
module tb_pingpong_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pingpong_frame_ctrl_if #(.IDX_W(3), .DROP_W(16)) bus ();
  pingpong_frame_ctrl #(.FRAME_LEN(8), .IDX_W(3), .DROP_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic rdy, input logic dn);
    bus.bit_valid   = bv;
    bus.frame_ready = rdy;
    bus.frame_done  = dn;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_frame();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got=%0b exp=0", bus.wr_bank); end
    checks++; if (bus.wr_idx !== 3'd0) begin errors++; $display("FAIL reset_wr_idx got=%0d exp=0", bus.wr_idx); end
    checks++; if (bus.rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got=%0b exp=0", bus.rd_bank); end
    checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL reset_bank_full got=%b exp=00", bus.bank_full); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got=%0b exp=0", bus.frame_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
    checks++; if (bus.frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped got=%0d exp=0", bus.frames_dropped); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", bus.wr_en); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (bus.wr_idx !== 3'(i) || bus.wr_en !== 1'b1) begin errors++; $display("FAIL single_idx bit=%0d got idx=%0d en=%0b exp idx=%0d en=1", i, bus.wr_idx, bus.wr_en, i); end
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.bank_full !== 2'b01) begin errors++; $display("FAIL single_full got=%b exp=01", bus.bank_full); end
    checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL single_wr_bank got=%0b exp=1", bus.wr_bank); end
    checks++; if (bus.wr_idx !== 3'd0) begin errors++; $display("FAIL single_wrap got=%0d exp=0", bus.wr_idx); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL single_fv0 got=%0b exp=0", bus.frame_valid); end
    step();
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL single_fv1 got=%0b exp=0", bus.frame_valid); end
    step();
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL single_fv2 got=%0b exp=1", bus.frame_valid); end
    drive(1'b0, 1'b1, 1'b0);
    step();
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL single_accept got=%0b exp=0", bus.frame_valid); end
    drive(1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL single_release got=%b exp=00", bus.bank_full); end
    checks++; if (bus.rd_bank !== 1'b1) begin errors++; $display("FAIL single_rd_bank got=%0b exp=1", bus.rd_bank); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (bus.wr_en !== (i < 16)) begin errors++; $display("FAIL ovf_wr_en bit=%0d got=%0b exp=%0b", i, bus.wr_en, i < 16); end
      step();
      checks++; if (bus.overflow !== (i == 16 || i == 24)) begin errors++; $display("FAIL ovf_pulse bit=%0d got=%0b exp=%0b", i, bus.overflow, i == 16 || i == 24); end
      if (i == 15) begin
        checks++; if (bus.bank_full !== 2'b11 || bus.wr_bank !== 1'b1) begin errors++; $display("FAIL ovf_both_full got full=%b bank=%0b exp full=11 bank=1", bus.bank_full, bus.wr_bank); end
      end
      if (i == 22 || i == 23 || i == 31) begin
        checks++; if (bus.frames_dropped !== (i == 22 ? 16'd0 : i == 23 ? 16'd1 : 16'd2)) begin errors++; $display("FAIL ovf_dropped bit=%0d got=%0d", i, bus.frames_dropped); end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL ovf_fv got=%0b exp=1", bus.frame_valid); end
  endtask

  task automatic test_done_coincide();
    apply_reset();
    write_frame();
    step();
    step();
    drive(1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL coin_wr_bank got=%0b exp=0", bus.wr_bank); end
    checks++; if (bus.bank_full !== 2'b10) begin errors++; $display("FAIL coin_full got=%b exp=10", bus.bank_full); end
    checks++; if (bus.rd_bank !== 1'b1) begin errors++; $display("FAIL coin_rd_bank got=%0b exp=1", bus.rd_bank); end
    checks++; if (bus.frames_dropped !== 16'd0) begin errors++; $display("FAIL coin_dropped got=%0d exp=0", bus.frames_dropped); end
    drive(1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL coin_wr_en got=%0b exp=1", bus.wr_en); end
    step();
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL coin_overflow got=%0b exp=0", bus.overflow); end
  endtask

  task automatic test_gapped();
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      drive(k % 2 == 0, 1'b0, 1'b0);
      #1;
      checks++; if (bus.wr_idx !== 3'((k + 1) / 2)) begin errors++; $display("FAIL gap_idx cycle=%0d got=%0d exp=%0d", k, bus.wr_idx, (k + 1) / 2); end
      if (k == 14) begin
        checks++; if (bus.bank_full !== 2'b00) begin errors++; $display("FAIL gap_early_full got=%b exp=00", bus.bank_full); end
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.bank_full !== 2'b01 || bus.wr_idx !== 3'd0 || bus.wr_bank !== 1'b1) begin errors++; $display("FAIL gap_end got full=%b idx=%0d bank=%0b exp full=01 idx=0 bank=1", bus.bank_full, bus.wr_idx, bus.wr_bank); end
  endtask

  task automatic test_spurious();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0);
    step();
    step();
    checks++; if (bus.frame_valid !== 1'b0 || bus.bank_full !== 2'b00) begin errors++; $display("FAIL spur_idle_ready got fv=%0b full=%b exp fv=0 full=00", bus.frame_valid, bus.bank_full); end
    drive(1'b0, 1'b0, 1'b1);
    step();
    write_frame();
    step();
    step();
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL spur_offer got=%0b exp=1", bus.frame_valid); end
    drive(1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1 || bus.bank_full !== 2'b01 || bus.rd_bank !== 1'b0) begin errors++; $display("FAIL spur_done got fv=%0b full=%b rd=%0b exp fv=1 full=01 rd=0", bus.frame_valid, bus.bank_full, bus.rd_bank); end
    step();
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL spur_hold got=%0b exp=1", bus.frame_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    write_frame();
    step();
    step();
    drive(1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1);
    step();
    write_frame();
    step();
    step();
    drive(1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.wr_idx !== 3'd5 || bus.bank_full !== 2'b10 || bus.rd_bank !== 1'b1 || bus.frame_valid !== 1'b0) begin errors++; $display("FAIL mid_setup got idx=%0d full=%b rd=%0b fv=%0b exp idx=5 full=10 rd=1 fv=0", bus.wr_idx, bus.bank_full, bus.rd_bank, bus.frame_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.wr_idx !== 3'd0 || bus.wr_bank !== 1'b0) begin errors++; $display("FAIL mid_async_wr got idx=%0d bank=%0b exp idx=0 bank=0", bus.wr_idx, bus.wr_bank); end
    checks++; if (bus.bank_full !== 2'b00 || bus.rd_bank !== 1'b0 || bus.frame_valid !== 1'b0) begin errors++; $display("FAIL mid_async_rd got full=%b rd=%0b fv=%0b exp full=00 rd=0 fv=0", bus.bank_full, bus.rd_bank, bus.frame_valid); end
    checks++; if (bus.overflow !== 1'b0 || bus.frames_dropped !== 16'd0) begin errors++; $display("FAIL mid_async_drop got ovf=%0b dropped=%0d exp 0 0", bus.overflow, bus.frames_dropped); end
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.wr_idx !== 3'd0 || bus.wr_bank !== 1'b0 || bus.wr_en !== 1'b1) begin errors++; $display("FAIL mid_restart got idx=%0d bank=%0b en=%0b exp idx=0 bank=0 en=1", bus.wr_idx, bus.wr_bank, bus.wr_en); end
    step();
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.wr_idx !== 3'd1) begin errors++; $display("FAIL mid_advance got=%0d exp=1", bus.wr_idx); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    test_reset();
    test_single_frame();
    test_overflow();
    test_done_coincide();
    test_gapped();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
